station_ctrl: RTL and testbench

STATION_CTRL -- requirements
Module: station_ctrl

---
 rtl/station_pkg.sv | 20 ++
 rtl/tmo_timer.sv | 46 ++++
 rtl/station_ctrl.sv | 169 ++++++++++++++++
 tb/tb_station_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/station_pkg.sv
// station_pkg -- shared types and constants for the station controller.
//   state_e  : controller states (IDLE, TRANSIT)
//   OP_STOP  : command opcode that halts the robot
//   OP_GO    : command opcode that starts a trip to cmd[5:0]
//   TMO_W    : width of the transit timeout counter
//   TMO_MAX  : saturation value of the timeout counter
package station_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_e;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    localparam int unsigned          TMO_W   = 22;
    localparam logic [TMO_W-1:0]     TMO_MAX = 22'h3FFFFF;

endpackage

// File: rtl/tmo_timer.sv
// tmo_timer -- saturating transit timeout counter.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear (wins over en)
//   en      : count one step this cycle
//   expired : counter has reached LIMIT while enabled
module tmo_timer
    import station_pkg::*;
#(
    parameter logic [TMO_W-1:0] LIMIT = TMO_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear, or step up and stick at the all-ones value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 22'd0;
        end else if (en && (cnt_q != TMO_MAX)) begin
            cnt_d = cnt_q + 22'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 22'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // >= keeps the flag asserted even if LIMIT equals the saturation value.
    assign expired = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/station_ctrl.sv
// station_ctrl -- drives a robot between barcode-labelled stations.
// Optional feature: define STATION_BUZZ_EN to drive a square wave on buzz
// while the robot moves; otherwise buzz is tied low.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_rdy, cmd        : command strobe; [15:14] opcode, [5:0] destination
//   clr_cmd_rdy         : combinational command consume
//   ID_vld, ID          : barcode station ID strobe and value
//   clr_ID_vld          : combinational ID consume
//   go                  : registered, high exactly while in TRANSIT
//   arrived, tmo        : registered one-cycle pulses (destination hit / timeout)
//   buzz                : registered piezo drive
module station_ctrl
    import station_pkg::*;
#(
    parameter logic [21:0] TMO_CYC   = 22'h3FFFFF,
    parameter logic [15:0] BUZZ_HALF = 16'd25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [15:0] cmd,
    output logic        clr_cmd_rdy,
    input  logic        ID_vld,
    input  logic [7:0]  ID,
    output logic        clr_ID_vld,
    output logic        go,
    output logic        arrived,
    output logic        tmo,
    output logic        buzz
);

    state_e      state_q, state_d;
    logic [5:0]  dest_q, dest_d;
    logic        go_q, go_d;
    logic        arrived_q, arrived_d;
    logic        tmo_q, tmo_d;
    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic        tmr_exp_s;
    logic [1:0]  op_s;
    logic        id_hit_s;
    logic        unused_s;

    assign op_s     = cmd[15:14];
    assign id_hit_s = (ID[5:0] == dest_q);

    // Consumes are pure strobes, held low during reset.
    assign clr_cmd_rdy = cmd_rdy & rst_n;
    assign clr_ID_vld  = ID_vld & rst_n;

    // Upper command/ID bits and (in the default build) BUZZ_HALF carry no meaning here.
    assign unused_s = ^{cmd[13:6], ID[7:6], BUZZ_HALF};

    // State transitions; a command always shadows a coincident ID.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        arrived_d = 1'b0;
        tmo_d     = 1'b0;
        tmr_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                // Holding the timer cleared in IDLE gives a zero count on TRANSIT entry.
                tmr_clr_s = 1'b1;
                if (cmd_rdy && (op_s == OP_GO)) begin
                    state_d = TRANSIT;
                    dest_d  = cmd[5:0];
                end else begin
                    state_d = IDLE;
                end
            end
            TRANSIT: begin
                if (cmd_rdy && (op_s == OP_GO)) begin
                    dest_d    = cmd[5:0];
                    tmr_clr_s = 1'b1;
                end else if (cmd_rdy && (op_s == OP_STOP)) begin
                    state_d = IDLE;
                end else if (ID_vld && !cmd_rdy && id_hit_s) begin
                    state_d   = IDLE;
                    arrived_d = 1'b1;
                end else if (ID_vld && !cmd_rdy) begin
                    // Passing any station proves progress: restart the timeout.
                    tmr_clr_s = 1'b1;
                end else if (tmr_exp_s) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = TRANSIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign go_d     = (state_d == TRANSIT);
    assign tmr_en_s = (state_q == TRANSIT);

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dest_q    <= 6'd0;
            go_q      <= 1'b0;
            arrived_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            go_q      <= go_d;
            arrived_q <= arrived_d;
            tmo_q     <= tmo_d;
        end
    end

    tmo_timer #(
        .LIMIT(TMO_CYC)
    ) u_tmo_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_s),
        .en     (tmr_en_s),
        .expired(tmr_exp_s)
    );

    assign go      = go_q;
    assign arrived = arrived_q;
    assign tmo     = tmo_q;

`ifdef STATION_BUZZ_EN
    logic [15:0] bz_cnt_q, bz_cnt_d;
    logic        buzz_q, buzz_d;

    // Half-period divider runs off the registered go, so buzz drops the cycle after go falls.
    always_comb begin
        bz_cnt_d = bz_cnt_q;
        buzz_d   = buzz_q;
        if (go_q) begin
            if (bz_cnt_q == (BUZZ_HALF - 16'd1)) begin
                bz_cnt_d = 16'd0;
                buzz_d   = ~buzz_q;
            end else begin
                bz_cnt_d = bz_cnt_q + 16'd1;
                buzz_d   = buzz_q;
            end
        end else begin
            bz_cnt_d = 16'd0;
            buzz_d   = 1'b0;
        end
    end

    // Buzz registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bz_cnt_q <= 16'd0;
            buzz_q   <= 1'b0;
        end else begin
            bz_cnt_q <= bz_cnt_d;
            buzz_q   <= buzz_d;
        end
    end

    assign buzz = buzz_q;
`else
    assign buzz = 1'b0;
`endif

endmodule

// File: tb/tb_station_ctrl.sv
module tb_station_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_rdy = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        clr_cmd_rdy;
    logic        ID_vld = 1'b0;
    logic [7:0]  ID = 8'h00;
    logic        clr_ID_vld;
    logic        go;
    logic        arrived;
    logic        tmo;
    logic        buzz;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [2:0] outs;   // {go, arrived, tmo}
    } ev_t;

    ev_t  exp_q[$];
    logic prev_go = 1'b0;

    station_ctrl #(
        .TMO_CYC  (22'd100),
        .BUZZ_HALF(16'd4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID_vld     (ID_vld),
        .ID         (ID),
        .clr_ID_vld (clr_ID_vld),
        .go         (go),
        .arrived    (arrived),
        .tmo        (tmo),
        .buzz       (buzz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: any go edge or arrived/tmo pulse must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if ((go !== prev_go) || (arrived !== 1'b0) || (tmo !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_event: actual go/arr/tmo=%b at cycle %0d, expected none",
                         {go, arrived, tmo}, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_outputs", {29'd0, go, arrived, tmo}, {29'd0, e.outs});
            end
        end
        prev_go = go;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input cycle; optionally queue the event expected on the following cycle.
    task automatic step(input logic cr, input logic [15:0] c, input logic iv, input logic [7:0] id,
                        input logic ev, input logic [2:0] outs);
        if (ev) exp_q.push_back(ev_t'{cyc + 1, outs});
        cmd_rdy = cr;
        cmd     = c;
        ID_vld  = iv;
        ID      = id;
        #1;
        chk("clr_cmd_rdy", {31'd0, clr_cmd_rdy}, {31'd0, cr});
        chk("clr_ID_vld", {31'd0, clr_ID_vld}, {31'd0, iv});
        tick();
        cmd_rdy = 1'b0;
        ID_vld  = 1'b0;
    endtask

    initial begin
        int   m;
        logic eb;

        // Reset: outputs low and consumes suppressed even with both strobes up.
        #1;
        rst_n   = 1'b0;
        cmd_rdy = 1'b1;
        cmd     = 16'h4005;
        ID_vld  = 1'b1;
        ID      = 8'h05;
        repeat (2) tick();
        chk("rst_clr_cmd_rdy", {31'd0, clr_cmd_rdy}, 32'd0);
        chk("rst_clr_ID_vld", {31'd0, clr_ID_vld}, 32'd0);
        chk("rst_outputs", {28'd0, go, arrived, tmo, buzz}, 32'd0);
        cmd_rdy = 1'b0;
        ID_vld  = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("idle_go", {31'd0, go}, 32'd0);

        // GO to station 5, wrong station 3, then station 5.
        step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1, 3'b100);
        step(1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 3'b000);
        tick();
        chk("go_after_mismatch", {31'd0, go}, 32'd1);
        step(1'b0, 16'h0000, 1'b1, 8'h05, 1'b1, 3'b010);
        tick();
        chk("go_after_arrive", {31'd0, go}, 32'd0);

        // IDs in IDLE and STOP / illegal opcodes in IDLE do nothing.
        step(1'b0, 16'h0000, 1'b1, 8'h05, 1'b0, 3'b000);
        step(1'b1, 16'hC005, 1'b0, 8'h00, 1'b0, 3'b000);
        step(1'b1, 16'h8005, 1'b0, 8'h00, 1'b0, 3'b000);
        step(1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 3'b000);
        tick();
        chk("idle_ignores", {31'd0, go}, 32'd0);

        // GO while moving re-targets: 5 is now a mismatch, 7 arrives.
        step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1, 3'b100);
        step(1'b1, 16'h4007, 1'b0, 8'h00, 1'b0, 3'b000);
        step(1'b0, 16'h0000, 1'b1, 8'h05, 1'b0, 3'b000);
        tick();
        chk("go_after_relatch", {31'd0, go}, 32'd1);
        step(1'b0, 16'h0000, 1'b1, 8'h87, 1'b1, 3'b010);

        // STOP and matching ID together: command wins, no arrived.
        step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1, 3'b100);
        tick();
        step(1'b1, 16'h0000, 1'b1, 8'h05, 1'b1, 3'b000);
        repeat (3) tick();

        // Plain timeout: TRANSIT cycles 1..101 with go high, tmo the cycle after.
        m = cyc;
        step(1'b1, 16'h4010, 1'b0, 8'h00, 1'b1, 3'b100);
        exp_q.push_back(ev_t'{m + 102, 3'b001});
        while (cyc < m + 105) tick();
        chk("go_after_tmo", {31'd0, go}, 32'd0);

        // A passing station at cycle 60 restarts the timeout.
        m = cyc;
        step(1'b1, 16'h4010, 1'b0, 8'h00, 1'b1, 3'b100);
        while (cyc < m + 60) tick();
        step(1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 3'b000);
        exp_q.push_back(ev_t'{m + 162, 3'b001});
        while (cyc < m + 166) tick();

        // Buzz: with BUZZ_HALF=4 first toggle lands 5 cycles after the GO cycle.
        m = cyc;
        step(1'b1, 16'h4020, 1'b0, 8'h00, 1'b1, 3'b100);
        for (int k = 1; k <= 16; k++) begin
`ifdef STATION_BUZZ_EN
            eb = (k >= 5) ? ((((k - 5) / 4) % 2) == 0) : 1'b0;
`else
            eb = 1'b0;
`endif
            chk("buzz_wave", {31'd0, buzz}, {31'd0, eb});
            tick();
        end
        step(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 3'b000);
        tick();
        chk("buzz_after_stop", {31'd0, buzz}, 32'd0);

        // Reset mid-TRANSIT drops go/buzz at once; controller is idle afterwards.
        step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1, 3'b100);
        repeat (5) tick();
        exp_q.push_back(ev_t'{cyc, 3'b000});
        rst_n = 1'b0;
        #1;
        chk("midrst_go", {31'd0, go}, 32'd0);
        chk("midrst_buzz", {31'd0, buzz}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_go", {31'd0, go}, 32'd0);
        step(1'b0, 16'h0000, 1'b1, 8'h05, 1'b0, 3'b000);
        step(1'b1, 16'h4005, 1'b0, 8'h00, 1'b1, 3'b100);
        step(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 3'b000);

        repeat (5) tick();
        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
